pipe_add_stall: RTL and testbench
=================================

PIPE_ADD_STALL -- requirements
Module: pipe_add_stall

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits, legal range 1..64.
REQ-002 Parameter STAGES, default 2: number of register stages, legal range 1..8.
REQ-003 Parameter INCREMENT, default 1: unsigned constant added to each input, truncated to WIDTH bits.
REQ-004 Parameter SATURATE, default 0: 0 selects wrap mode, 1 selects saturating mode.
REQ-005 Port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 Port flush, input, 1 bit: synchronous clear of all in-flight items.
REQ-008 Port input_valid, input, 1 bit: x carries an item.
REQ-009 Port input_ready, output, 1 bit: the block accepts x this cycle.
REQ-010 Port x, input, WIDTH bits: operand.
REQ-011 Port output_valid, output, 1 bit: out and ovf carry an item.
REQ-012 Port output_ready, input, 1 bit: downstream accepts out this cycle.
REQ-013 Port out, output, WIDTH bits: result.
REQ-014 Port ovf, output, 1 bit: the item's x + INCREMENT exceeded 2^WIDTH-1.
REQ-015 Port occupancy, output, clog2(STAGES+1) bits: number of valid stages.

Function
REQ-016 Transfer in when input_valid && input_ready; transfer out when output_valid && output_ready.
REQ-017 Each stage holds a valid bit, WIDTH data bits and an ovf bit; stage STAGES-1 drives output_valid, out and ovf.
REQ-018 Stage k advances when it is empty or stage k+1 advances; the last stage advances when it is empty or output_ready is high.
REQ-019 input_ready = stage 0 advances && !flush; it combinationally depends on output_ready (no skid buffer).
REQ-020 Sum computed between x and stage 0 at WIDTH+1 bits; ovf = bit WIDTH of the sum; later stages pass data unchanged.
REQ-021 Wrap mode stores sum[WIDTH-1:0]; saturating mode stores all-ones when ovf = 1, else sum[WIDTH-1:0].
REQ-022 Latency is exactly STAGES cycles from input transfer to output_valid when unstalled; throughput is one item per cycle.
REQ-023 A stalled stage holds valid, data and ovf unchanged; items are never dropped, duplicated or reordered.
REQ-024 Data and ovf registers load only when their stage advances and the incoming valid is 1; they have no reset.
REQ-025 Flush high clears all stage valid bits at the next edge, suppresses input acceptance and overrides simultaneous input and output transfers; out/ovf values are don't-care afterward.
REQ-026 occupancy = population count of stage valid bits; range 0..STAGES.
REQ-027 With all stages full and output_ready low, input_ready is low; when output_ready rises, input_ready rises in the same cycle.

Reset
REQ-028 rst low immediately clears every stage valid bit: output_valid = 0, occupancy = 0, input_ready = 0 while rst is low.
REQ-029 out and ovf are undefined after reset until the first output_valid.
REQ-030 Reset asserted mid-operation discards all in-flight items; the first input accepted after rst deasserts appears after STAGES cycles.

Structure
REQ-031 Package pipe_add_pkg holds mode constants MODE_WRAP = 0 and MODE_SAT = 1 and a function computing occupancy width from STAGES.
REQ-032 Sub-module pipe_add_stage (valid/data/ovf register with advance and flush) is instantiated STAGES times via generate; the adder lives in the top level.

Verification
REQ-033 WIDTH=32, STAGES=2, INCREMENT=1, output_ready=1; x=5 then 6 back-to-back -> out=6, then out=7 on consecutive cycles, 2 cycles after acceptance, ovf=0.
REQ-034 Wrap mode, x=32'hFFFF_FFFF -> out=0, ovf=1; saturating mode, same x -> out=32'hFFFF_FFFF, ovf=1.
REQ-035 STAGES=4, stream 10 items with output_ready held low for 6 cycles mid-stream -> occupancy reaches 4, input_ready = 0 while full, all 10 results arrive in order.
REQ-036 Pipeline full, flush and input_valid both high for 1 cycle -> next cycle occupancy = 0, output_valid = 0, input not accepted.
REQ-037 rst pulsed low asynchronously between edges with 2 items in flight -> output_valid falls immediately and no stale item emerges after release.
REQ-038 STAGES=1, WIDTH=8, INCREMENT=255, x=1 -> out=0 (wrap) with ovf=1, latency 1 cycle.

Source files
------------

// File: rtl/pipe_add_pkg.sv
// Shared constants for the stallable add-a-constant pipeline.
package pipe_add_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Bits needed to count 0..stages valid stages.
    function automatic int occ_width(input int stages);
        return (stages < 1) ? 1 : $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/pipe_add_stage.sv
// One pipeline register: valid bit with async clear and flush; payload without reset.
module pipe_add_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             advance,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    input  logic             prev_ovf,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             ovf
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (advance) begin
            valid <= prev_valid;
        end
    end

    // Payload only moves with a real item, so a stalled or empty stage keeps its contents.
    always_ff @(posedge clk) begin
        if (advance && prev_valid) begin
            data <= prev_data;
            ovf  <= prev_ovf;
        end
    end

endmodule

// File: rtl/pipe_add_stall.sv
// Adds INCREMENT to each input item and carries it through STAGES stallable registers.
module pipe_add_stall
    import pipe_add_pkg::*;
#(
    parameter int              WIDTH     = 32,
    parameter int              STAGES    = 2,
    parameter longint unsigned INCREMENT = 1,
    parameter int              SATURATE  = MODE_WRAP
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            input_valid,
    output logic                            input_ready,
    input  logic [WIDTH-1:0]                x,
    output logic                            output_valid,
    input  logic                            output_ready,
    output logic [WIDTH-1:0]                out,
    output logic                            ovf,
    output logic [occ_width(STAGES)-1:0]    occupancy
);

    localparam int               OCC_W = occ_width(STAGES);
    localparam logic [WIDTH-1:0] INC   = WIDTH'(INCREMENT);

    // Handshake: an item moves across a port on a rising edge where valid && ready are
    // both high; input_ready is combinational from output_ready, flush and rst.
    logic [STAGES-1:0] stage_valid;
    logic [WIDTH-1:0]  stage_data [STAGES];
    logic [STAGES-1:0] stage_ovf;
    logic [STAGES-1:0] advance;

    logic [WIDTH:0]    sum;
    logic              sum_ovf;
    logic [WIDTH-1:0]  sum_data;
    logic              take;

    assign sum      = {1'b0, x} + {1'b0, INC};
    assign sum_ovf  = sum[WIDTH];
    assign sum_data = (SATURATE == MODE_SAT && sum_ovf) ? '1 : sum[WIDTH-1:0];

    // A stage can move when any stage at or downstream of it has a hole, or the sink drains.
    for (genvar k = 0; k < STAGES; k++) begin : g_advance
        assign advance[k] = output_ready || !(&stage_valid[STAGES-1:k]);
    end

    assign input_ready = rst && !flush && advance[0];
    assign take        = input_valid && input_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             prev_valid;
        logic [WIDTH-1:0] prev_data;
        logic             prev_ovf;

        if (k == 0) begin : g_head
            assign prev_valid = take;
            assign prev_data  = sum_data;
            assign prev_ovf   = sum_ovf;
        end else begin : g_body
            assign prev_valid = stage_valid[k-1];
            assign prev_data  = stage_data[k-1];
            assign prev_ovf   = stage_ovf[k-1];
        end

        pipe_add_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .advance    (advance[k]),
            .prev_valid (prev_valid),
            .prev_data  (prev_data),
            .prev_ovf   (prev_ovf),
            .valid      (stage_valid[k]),
            .data       (stage_data[k]),
            .ovf        (stage_ovf[k])
        );
    end

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < STAGES; k++) begin
            occupancy = occupancy + OCC_W'(stage_valid[k]);
        end
    end

    assign output_valid = stage_valid[STAGES-1];
    assign out          = stage_data[STAGES-1];
    assign ovf          = stage_ovf[STAGES-1];

endmodule

// File: tb/tb_pipe_add_stall.sv
// Drives three pipe_add_stall configurations from shared stimulus and scores each one.
module tb_pipe_add_stall;
    import pipe_add_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        input_valid;
    logic        output_ready;
    logic [31:0] x;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [64:0] got, input logic [64:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: x + inc at w+1 bits, ovf is the carry, saturate clamps to all-ones.
    function automatic logic [64:0] model(input logic [31:0] xv, input int w, input int inc,
                                          input int sat);
        logic [65:0] mask;
        logic [65:0] sum;
        logic [65:0] res;
        logic        c;
        mask = (66'd1 << w) - 66'd1;
        sum  = (66'(xv) & mask) + (66'(inc) & mask);
        c    = sum[w];
        res  = (sat == MODE_SAT && c) ? mask : (sum & mask);
        return {c, res[63:0]};
    endfunction

    for (genvar d = 0; d < 3; d++) begin : g_dut
        localparam int W   = (d == 2) ? 8 : 32;
        localparam int S   = (d == 0) ? 2 : (d == 1) ? 4 : 1;
        localparam int INC = (d == 2) ? 255 : 1;
        localparam int SAT = (d == 1) ? MODE_SAT : MODE_WRAP;
        localparam int OW  = occ_width(S);

        logic          input_ready;
        logic          output_valid;
        logic [W-1:0]  out;
        logic          ovf;
        logic [OW-1:0] occupancy;

        logic [64:0] exp_q[$];
        int          acc_q[$];
        int          cyc        = 0;
        int          last_stall = -1;

        pipe_add_stall #(
            .WIDTH     (W),
            .STAGES    (S),
            .INCREMENT (64'(INC)),
            .SATURATE  (SAT)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .flush        (flush),
            .input_valid  (input_valid),
            .input_ready  (input_ready),
            .x            (x[W-1:0]),
            .output_valid (output_valid),
            .output_ready (output_ready),
            .out          (out),
            .ovf          (ovf),
            .occupancy    (occupancy)
        );

        always @(negedge clk) begin
            logic [64:0] e;
            int          a;
            if (!rst) begin
                check($sformatf("d%0d_rst_valid", d), 65'(output_valid), 65'd0);
                check($sformatf("d%0d_rst_occ", d), 65'(occupancy), 65'd0);
                check($sformatf("d%0d_rst_ready", d), 65'(input_ready), 65'd0);
            end else begin
                check($sformatf("d%0d_input_ready", d), 65'(input_ready),
                      65'(!flush && (exp_q.size() < S || output_ready)));
                check($sformatf("d%0d_occupancy", d), 65'(occupancy), 65'(exp_q.size()));
                check($sformatf("d%0d_phantom_out", d),
                      65'(output_valid && exp_q.size() == 0), 65'd0);
                if (output_valid && output_ready && !flush && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    check($sformatf("d%0d_result", d), {ovf, 64'(out)}, e);
                    if (last_stall <= a) begin
                        check($sformatf("d%0d_latency", d), 65'(cyc - a), 65'(S));
                    end
                end
                if (flush) begin
                    exp_q.delete();
                    acc_q.delete();
                end else if (input_valid && input_ready) begin
                    exp_q.push_back(model(x, W, INC, SAT));
                    acc_q.push_back(cyc);
                end
                if (!output_ready) last_stall = cyc;
            end
            cyc++;
        end

        always @(negedge rst) begin
            exp_q.delete();
            acc_q.delete();
            #1;
            check($sformatf("d%0d_async_valid", d), 65'(output_valid), 65'd0);
            check($sformatf("d%0d_async_occ", d), 65'(occupancy), 65'd0);
        end
    end

    task automatic drive(input logic v, input logic [31:0] xv, input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        input_valid  = v;
        x            = xv;
        output_ready = ordy;
        flush        = fl;
    endtask

    function automatic logic [31:0] pick_x();
        case ($urandom_range(7))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'hFFFF_FF00 | 32'($urandom_range(255));
            2:       return 32'h0;
            3:       return 32'($urandom_range(255));
            default: return $urandom;
        endcase
    endfunction

    task automatic random_phase(input int n, input int ready_pct, input int flush_pct);
        for (int i = 0; i < n; i++) begin
            drive($urandom_range(99) < 70, pick_x(), $urandom_range(99) < ready_pct,
                  $urandom_range(99) < flush_pct);
        end
    endtask

    initial begin
        rst          = 1'b1;
        flush        = 1'b0;
        input_valid  = 1'b0;
        output_ready = 1'b1;
        x            = '0;
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b1, $urandom, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst         = 1'b1;
        input_valid = 1'b0;

        // Back-to-back small values, then the carry-out corner cases.
        drive(1'b1, 32'd5, 1'b1, 1'b0);
        drive(1'b1, 32'd6, 1'b1, 1'b0);
        drive(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        drive(1'b1, 32'd1, 1'b1, 1'b0);
        drive(1'b1, 32'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b0, 32'd0, 1'b1, 1'b0);

        random_phase(300, 70, 2);
        for (int i = 0; i < 6; i++) drive(1'b0, 32'd0, 1'b1, 1'b0);

        // Stream with a six-cycle downstream stall in the middle.
        for (int i = 0; i < 16; i++) begin
            drive(i < 13, 32'(100 + i), !(i >= 3 && i <= 8), 1'b0);
        end
        for (int i = 0; i < 6; i++) drive(1'b0, 32'd0, 1'b1, 1'b0);

        // Fill completely, then flush while offering a new item.
        for (int i = 0; i < 6; i++) drive(1'b1, $urandom, 1'b0, 1'b0);
        drive(1'b1, $urandom, 1'b0, 1'b1);
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 32'd0, 1'b1, 1'b0);

        // Asynchronous reset pulse between edges with two items in flight.
        drive(1'b1, 32'd11, 1'b1, 1'b0);
        drive(1'b1, 32'd12, 1'b1, 1'b0);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        #1 rst = 1'b0;
        #2 rst = 1'b1;
        for (int i = 0; i < 6; i++) drive(1'b0, 32'd0, 1'b1, 1'b0);
        drive(1'b1, 32'd20, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b0, 32'd0, 1'b1, 1'b0);

        random_phase(300, 50, 1);
        for (int i = 0; i < 20; i++) drive(1'b0, 32'd0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("d0_drained", 65'(g_dut[0].exp_q.size()), 65'd0);
        check("d1_drained", 65'(g_dut[1].exp_q.size()), 65'd0);
        check("d2_drained", 65'(g_dut[2].exp_q.size()), 65'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
